mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory port between the instruction-fetch port (IF stage) and the
//  data port (MEM stage). Single-outstanding, registered bus drive, active-low ack from
//  memory, data-priority arbitration with starvation guard, per-transfer watchdog timeout.
//  Sits between the core top level and the single-ported memory.
// PARAMETERS
//  D_STREAK_MAX  4      consecutive data grants allowed while i_req pending; then one fetch wins
//  TIMEOUT       15     BUSY cycles without ack before transfer is aborted with bus_err
//  FETCH_SIZE    2'b00  m_size code driven for instruction fetches (word)
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   reset, asynchronous, active-low
//  i_req    in   1   fetch request; held with i_addr stable until i_ack
//  i_addr   in   32  fetch address
//  i_rdata  out  32  fetched word, valid while i_ack=1
//  i_ack    out  1   one-cycle fetch completion pulse
//  d_req    in   1   data request; held with d_* stable until d_ack
//  d_write  in   1   1=store, 0=load
//  d_size   in   2   access size code, passed to m_size
//  d_addr   in   32  data address
//  d_wdata  in   32  store data
//  d_rdata  out  32  load data, valid while d_ack=1
//  d_ack    out  1   one-cycle data completion pulse
//  bus_err  out  1   high with i_ack/d_ack when transfer ended by timeout
//  stall    out  1   (i_req&~i_ack)|(d_req&~d_ack), combinational, to hazard unit
//  m_req    out  1   memory request
//  m_write  out  1   memory write strobe, only ever high with m_req
//  m_size   out  2   memory access size
//  m_addr   out  32  memory address
//  m_wdata  out  32  memory write data (tristate on DDT handled outside)
//  m_rdata  in   32  memory read data
//  m_ack_n  in   1   memory acknowledge, active-low, sampled on clk rising edge
// BEHAVIOUR
//  - rst low: state=IDLE, streak=0, wdog=0; all outputs 0 except stall (combinational). Async;
//    mid-transfer reset abandons transfer, no ack is ever issued for it.
//  - States: IDLE -> BUSY_I | BUSY_D -> DONE -> IDLE. All m_* and ack/rdata/bus_err registered.
//  - IDLE: arbitrate on sampled requests. d_req&~i_req -> BUSY_D. i_req&~d_req -> BUSY_I.
//    Both: BUSY_D unless streak==D_STREAK_MAX, then BUSY_I. None: stay.
//  - streak: +1 (saturating) on each data grant made while i_req=1; cleared on fetch grant
//    and on data grant with i_req=0.
//  - BUSY_x: m_req=1, m_addr/m_size/m_write/m_wdata from granted port (fetch: m_write=0,
//    m_size=FETCH_SIZE, m_wdata=0). Held constant for the whole state. wdog counts up from 0.
//  - Edge with m_ack_n=0 in BUSY_x: latch m_rdata into x_rdata (loads/fetches; stores latch 0),
//    -> DONE with x_ack=1, bus_err=0, m_req=m_write=0.
//  - Edge with wdog==TIMEOUT-1 and m_ack_n=1: -> DONE with x_ack=1, bus_err=1, x_rdata=0.
//    Ack and timeout on same edge: ack wins.
//  - DONE: one cycle, ack pulse visible, no arbitration (requester still holds req this cycle).
//    Requester must drop or re-present req by next cycle. -> IDLE, acks/bus_err cleared.
//  - Latency: req high at edge E (IDLE) -> m_req high after E; ack sampled at edge A ->
//    x_ack high for the cycle after A. Minimum 3 cycles per transfer, zero wait states.
//  - m_ack_n low while not BUSY: ignored. x_rdata holds last value outside ack cycle.
// TESTING
//  1 Fetch only: i_req=1,i_addr=0x100, mem acks 2nd BUSY cycle with 0x2408000A -> m_req 2 cycles,
//    m_size=FETCH_SIZE, i_ack 1 cycle with i_rdata=0x2408000A, stall low that cycle.
//  2 Store: d_req=1,d_write=1,d_addr=0x400,d_wdata=0xDEADBEEF,d_size=2'b00 -> m_write=1,
//    m_wdata=0xDEADBEEF during BUSY_D only; d_ack pulse, bus_err=0.
//  3 Contention: i_req and d_req held high continuously, 0-wait memory -> grant order
//    D,D,D,D,I,D,D,D,D,I; no grant ever lost or duplicated.
//  4 Timeout: d_req=1, m_ack_n held 1 -> after 15 BUSY cycles d_ack=1,bus_err=1,d_rdata=0;
//    m_ack_n=0 on exactly the 15th cycle -> normal ack, bus_err=0.
//  5 Reset: rst low in 2nd BUSY_I cycle -> m_req=0 immediately; after release, no i_ack until
//    a fresh arbitration; state IDLE, streak 0.
//  6 Stray ack: m_ack_n=0 pulsed in IDLE and DONE -> no ack, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory port between fetch and data: data wins unless a fetch has waited D_STREAK_MAX grants.
// Latency: bus driven the cycle after grant; ack pulses the cycle after m_ack_n is seen low (min 3 cycles/transfer).
// Backpressure: single outstanding transfer; requesters hold req until ack, stall covers the wait.
module mem_bus_arbiter #(
  parameter int         D_STREAK_MAX = 4,
  parameter int         TIMEOUT      = 15,
  parameter logic [1:0] FETCH_SIZE   = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_err,
  output logic        stall,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  localparam int SW = $clog2(D_STREAK_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          m_req_q, m_req_d, m_write_q, m_write_d;
  logic [1:0]    m_size_q, m_size_d;
  logic [31:0]   m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic          i_ack_q, i_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          busy, acked, timed_out, fetch_due;
  logic [31:0]   rdata_in;

  assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign acked     = busy && !m_ack_n;
  assign timed_out = busy && m_ack_n && (wdog_q == WW'(TIMEOUT - 1));
  assign fetch_due = i_req && (streak_q == SW'(D_STREAK_MAX));
  // Stores return nothing; a timeout also returns zero data.
  assign rdata_in  = (acked && !m_write_q) ? m_rdata : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      streak_q  <= '0;
      wdog_q    <= '0;
      m_req_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      wdog_q    <= wdog_d;
      m_req_q   <= m_req_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && !fetch_due) state_d = BUSY_D;
        else if (i_req)          state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: if (acked || timed_out) state_d = DONE;
      default:        state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d  = streak_q;
    wdog_d    = wdog_q;
    m_req_d   = m_req_q;
    m_write_d = m_write_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (state_d == BUSY_D) begin
          if (!i_req)                             streak_d = '0;
          else if (streak_q != SW'(D_STREAK_MAX)) streak_d = streak_q + SW'(1);
          m_req_d   = 1'b1;
          m_write_d = d_write;
          m_size_d  = d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (state_d == BUSY_I) begin
          streak_d  = '0;
          m_req_d   = 1'b1;
          m_write_d = 1'b0;
          m_size_d  = FETCH_SIZE;
          m_addr_d  = i_addr;
          m_wdata_d = 32'h0;
        end
      end
      BUSY_I, BUSY_D: begin
        wdog_d = wdog_q + WW'(1);
        if (state_d == DONE) begin
          m_req_d   = 1'b0;
          m_write_d = 1'b0;
          m_size_d  = 2'b00;
          m_addr_d  = 32'h0;
          m_wdata_d = 32'h0;
          bus_err_d = timed_out;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = rdata_in;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = rdata_in;
          end
        end
      end
      default: ;
    endcase
  end

  assign m_req   = m_req_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign bus_err = bus_err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall   = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);
endmodule
